// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the debug-board run controller.
// Provides the FSM state encoding (as seen on state_out) and the default
// timing parameters used by the controller and its input conditioners.
package cpu_dbg_pkg;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_HALTED = 3'd1,
      S_RUN    = 3'd2,
      S_SLOW   = 3'd3,
      S_STEP   = 3'd4
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;
   localparam int unsigned DEF_SLOW_TICK_CYCLES  = 50_000_000;
   localparam int unsigned DEF_RESET_HOLD_CYCLES = 16;
   localparam int unsigned DEF_CNT_W             = 16;

   // Width of a down/up counter that must hold values 0..n-1 (at least 1 bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Input conditioner for one raw board button or switch.
// Two-flop synchroniser, then a stability counter: the debounced level only
// follows the synchronised input once it has differed from the current level
// for DEBOUNCE_CYCLES consecutive cycles. o_pulse is high for the single cycle
// in which the debounced level first reads 1.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (level clears to released)
//   i_raw    raw asynchronous input
//   o_level  debounced level
//   o_pulse  one-cycle rising-edge pulse of o_level
module btn_debounce
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_pulse
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_pulse;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_s1    <= i_raw;
         r_s2    <= r_s1;
         r_pulse <= 1'b0;
         if (r_s2 == r_level) begin
            // Any return to the accepted level restarts the stability window.
            r_cnt <= '0;
         end else if (r_cnt == CMAX) begin
            r_cnt   <= '0;
            r_level <= r_s2;
            r_pulse <= r_s2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_run_controller.sv
// Run-control sequencer for the RISC-V core on the FPGA debug board.
// Drives the core's reset and halt lines from board buttons and a switch,
// supporting reset-hold, halted, full-speed run, slow run (one release per
// prescaler period) and single step, and counts the cycles the core advanced.
// Ports:
//   CLK100MHZ      system clock
//   RST_N          asynchronous active-low reset
//   btn_reset/run/step/halt  raw buttons
//   sw_slow        raw switch, 1 = slow run
//   cpu_rst_n_out  core reset, active low
//   halt_out       core halt, 1 = frozen
//   state_out      current FSM state
//   adv_count      cycles with the core released since the last core reset
module cpu_run_controller
   import cpu_dbg_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SLOW_TICK_CYCLES  = DEF_SLOW_TICK_CYCLES,
   parameter int unsigned RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
   parameter int unsigned CNT_W             = DEF_CNT_W
) (
   input  logic             CLK100MHZ,
   input  logic             RST_N,
   input  logic             btn_reset,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_halt,
   input  logic             sw_slow,
   output logic             cpu_rst_n_out,
   output logic             halt_out,
   output logic [2:0]       state_out,
   output logic [CNT_W-1:0] adv_count
);

   localparam int unsigned PW = cnt_width(SLOW_TICK_CYCLES);
   localparam int unsigned HW = cnt_width(RESET_HOLD_CYCLES);
   localparam logic [PW-1:0] PMAX  = PW'(SLOW_TICK_CYCLES - 1);
   localparam logic [HW-1:0] HLOAD = HW'(RESET_HOLD_CYCLES - 1);

   logic w_p_reset;
   logic w_p_run;
   logic w_p_step;
   logic w_p_halt;
   logic w_slow;
   logic w_lvl_reset_unused;
   logic w_lvl_run_unused;
   logic w_lvl_step_unused;
   logic w_lvl_halt_unused;
   logic w_slow_pulse_unused;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
      .i_clk(CLK100MHZ), .i_rst_n(RST_N), .i_raw(btn_reset),
      .o_level(w_lvl_reset_unused), .o_pulse(w_p_reset)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .i_clk(CLK100MHZ), .i_rst_n(RST_N), .i_raw(btn_run),
      .o_level(w_lvl_run_unused), .o_pulse(w_p_run)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .i_clk(CLK100MHZ), .i_rst_n(RST_N), .i_raw(btn_step),
      .o_level(w_lvl_step_unused), .o_pulse(w_p_step)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
      .i_clk(CLK100MHZ), .i_rst_n(RST_N), .i_raw(btn_halt),
      .o_level(w_lvl_halt_unused), .o_pulse(w_p_halt)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slow (
      .i_clk(CLK100MHZ), .i_rst_n(RST_N), .i_raw(sw_slow),
      .o_level(w_slow), .o_pulse(w_slow_pulse_unused)
   );

   state_t           r_state;
   state_t           w_next;
   logic             r_cpu_rst_n;
   logic             r_halt;
   logic [HW-1:0]    r_hold;
   logic [PW-1:0]    r_presc;
   logic [CNT_W-1:0] r_adv;
   logic             w_tick;

   // Next state; pulse priority is reset > halt > step > run.
   always_comb begin
      w_next = r_state;
      if (w_p_reset) begin
         w_next = S_RESET;
      end else begin
         case (r_state)
            S_RESET:  if (r_hold == '0) w_next = S_HALTED;
            S_HALTED: begin
               if (w_p_halt)      w_next = S_HALTED;
               else if (w_p_step) w_next = S_STEP;
               else if (w_p_run)  w_next = w_slow ? S_SLOW : S_RUN;
            end
            S_RUN: begin
               if (w_p_halt)    w_next = S_HALTED;
               else if (w_slow) w_next = S_SLOW;
            end
            S_SLOW: begin
               if (w_p_halt)     w_next = S_HALTED;
               else if (!w_slow) w_next = S_RUN;
            end
            S_STEP:   w_next = S_HALTED;
            default:  w_next = S_RESET;
         endcase
      end
   end

   // A release is due when the prescaler completes a period and we stay in S_SLOW.
   assign w_tick = (r_state == S_SLOW) && (w_next == S_SLOW) && (r_presc == PMAX);

   // Outputs are decoded from the next state so they align with state_out.
   always_ff @(posedge CLK100MHZ or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_RESET;
         r_cpu_rst_n <= 1'b0;
         r_halt      <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_cpu_rst_n <= (w_next != S_RESET);
         r_halt      <= !((w_next == S_RUN) || (w_next == S_STEP) || w_tick);
      end
   end

   always_ff @(posedge CLK100MHZ or negedge RST_N) begin
      if (!RST_N) begin
         r_hold  <= HLOAD;
         r_presc <= '0;
         r_adv   <= '0;
      end else begin
         // Reloaded outside S_RESET and on any reset pulse, so each entry gets a full hold.
         if ((r_state != S_RESET) || w_p_reset) r_hold <= HLOAD;
         else if (r_hold != '0)                 r_hold <= r_hold - 1'b1;

         if ((r_state != S_SLOW) || (w_next != S_SLOW)) r_presc <= '0;
         else if (r_presc == PMAX)                      r_presc <= '0;
         else                                           r_presc <= r_presc + 1'b1;

         if (w_next == S_RESET)          r_adv <= '0;
         else if (!r_halt && r_cpu_rst_n) r_adv <= r_adv + 1'b1;
      end
   end

   assign cpu_rst_n_out = r_cpu_rst_n;
   assign halt_out      = r_halt;
   assign state_out     = r_state;
   assign adv_count     = r_adv;

endmodule
